// File: rtl/ifu_pc_fetch.sv
// ifu_pc_fetch
//
// Instruction fetch unit. This block owns the architectural PC. For each
// instruction it does the following, in order:
//   1. Issue one instruction-memory read through a valid/ready request
//      channel.
//   2. Capture the response word.
//   3. Present the word to decode.
//   4. Wait for execute to commit the next PC.
// A committed PC that is not word-aligned parks the unit in a terminal error
// state. Only reset leaves that state.
//
// Ports:
//   clk              clock; all state updates on the rising edge
//   rst              synchronous active-low reset (0 = reset)
//   imem_req_valid   fetch request valid (held until accepted)
//   imem_req_ready   memory accepts the request
//   imem_addr        fetch address, always equal to pc_out
//   imem_resp_valid  response word valid
//   imem_resp_data   fetched instruction word
//   inst             instruction presented to decode
//   inst_valid       inst holds a valid instruction
//   inst_ready       decode consumes inst
//   pc_out           current PC
//   pc_in            next PC from execute
//   pc_w_en          execute commits pc_in
//   fetch_err        sticky flag: a misaligned pc_in was committed
//   fetch_cnt        number of committed instructions (wraps silently)
module ifu_pc_fetch #(
  parameter int unsigned            ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0]   RESET_PC  = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ISA_WIDTH-1:0] imem_addr,
  input  logic                 imem_resp_valid,
  input  logic [ISA_WIDTH-1:0] imem_resp_data,
  output logic [ISA_WIDTH-1:0] inst,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [ISA_WIDTH-1:0] pc_out,
  input  logic [ISA_WIDTH-1:0] pc_in,
  input  logic                 pc_w_en,
  output logic                 fetch_err,
  output logic [ISA_WIDTH-1:0] fetch_cnt
);

  typedef enum logic [2:0] {
    REQ  = 3'd0,
    WAIT = 3'd1,
    HOLD = 3'd2,
    EXEC = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t state;

  // Word alignment of a committed target.
  function automatic logic is_aligned(input logic [ISA_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= REQ;
      pc_out    <= RESET_PC;
      inst      <= '0;
      fetch_err <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        // Responses seen here are ignored. A response that arrives after a
        // reset belongs to a request issued before the reset.
        REQ: begin
          if (imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            inst  <= imem_resp_data;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) state <= EXEC;
        end
        // Leaving EXEC on the commit edge means a held pc_w_en commits
        // only once. The unit ignores pc_w_en in every other state.
        EXEC: begin
          if (pc_w_en) begin
            pc_out    <= pc_in;
            fetch_cnt <= fetch_cnt + ISA_WIDTH'(1);
            if (is_aligned(pc_in)) begin
              state <= REQ;
            end else begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= ERR;
        end
      endcase
    end
  end

  // Outputs are decodes of registered state only. No input reaches an
  // output combinationally. Because pc_out only moves in EXEC, the address
  // is stable for as long as a request is pending.
  assign imem_req_valid = (state == REQ);
  assign inst_valid     = (state == HOLD);
  assign imem_addr      = pc_out;

endmodule

// File: tb/tb_ifu_pc_fetch.sv
module tb_ifu_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_in;
  logic        pc_w_en;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ifu_pc_fetch #(.ISA_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .pc_out         (pc_out),
    .pc_in          (pc_in),
    .pc_w_en        (pc_w_en),
    .fetch_err      (fetch_err),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle 1ns. Inputs are changed and outputs are
  // sampled here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: from REQ, run one fetch through to EXEC.
  task automatic go_exec(input logic [31:0] word);
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = word;
    tick();                         // REQ -> WAIT
    tick();                         // WAIT -> HOLD
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    tick();                         // HOLD -> EXEC
    inst_ready      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (pc_out !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h8000_0000); end
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 1", imem_req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", inst); end
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", fetch_err); end
    n_checks++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", fetch_cnt); end
  endtask

  task automatic test_free_run();
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0010_0093;
    inst_ready      = 1'b0;
    rst = 1'b1;
    n_checks++; if (imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL free_addr: got %h expected %h", imem_addr, 32'h8000_0000); end
    tick();                         // accepted -> WAIT
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL free_wait_req: got %b expected 0", imem_req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL free_wait_iv: got %b expected 0", inst_valid); end
    tick();                         // response latched -> HOLD
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL free_iv: got %b expected 1", inst_valid); end
    n_checks++; if (inst !== 32'h0010_0093) begin n_fail++; $display("FAIL free_inst: got %h expected %h", inst, 32'h0010_0093); end
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    tick();                         // -> EXEC
    inst_ready      = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL free_exec_iv: got %b expected 0", inst_valid); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL free_exec_req: got %b expected 0", imem_req_valid); end
  endtask

  task automatic test_seq_commit();
    pc_in   = 32'h8000_0004;
    pc_w_en = 1'b1;
    tick();
    pc_w_en = 1'b0;
    n_checks++; if (pc_out !== 32'h8000_0004) begin n_fail++; $display("FAIL seq_pc: got %h expected %h", pc_out, 32'h8000_0004); end
    n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL seq_cnt: got %0d expected 1", fetch_cnt); end
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL seq_req: got %b expected 1", imem_req_valid); end
    n_checks++; if (imem_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL seq_addr: got %h expected %h", imem_addr, 32'h8000_0004); end
    go_exec(32'h0020_0113);
    n_checks++; if (inst !== 32'h0020_0113) begin n_fail++; $display("FAIL seq_inst2: got %h expected %h", inst, 32'h0020_0113); end
    pc_in   = 32'h8000_0100;
    pc_w_en = 1'b1;
    tick();
    pc_w_en = 1'b0;
    n_checks++; if (imem_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL jump_addr: got %h expected %h", imem_addr, 32'h8000_0100); end
    n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL jump_cnt: got %0d expected 2", fetch_cnt); end
  endtask

  task automatic test_backpressure();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_req_valid[%0d]: got %b expected 1", i, imem_req_valid); end
      n_checks++; if (imem_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, imem_addr, 32'h8000_0100); end
    end
    imem_req_ready = 1'b1;
    tick();                         // -> WAIT
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hCAFE_0013;
    tick();                         // -> HOLD
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEAD_BEEF;
    inst_ready      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_iv[%0d]: got %b expected 1", i, inst_valid); end
      n_checks++; if (inst !== 32'hCAFE_0013) begin n_fail++; $display("FAIL bp_inst[%0d]: got %h expected %h", i, inst, 32'hCAFE_0013); end
    end
    inst_ready = 1'b1;
    tick();                         // -> EXEC
    inst_ready = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_iv_drop: got %b expected 0", inst_valid); end
    pc_in   = 32'h8000_0104;
    pc_w_en = 1'b1;
    tick();
    pc_w_en = 1'b0;
    n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 3", fetch_cnt); end
    n_checks++; if (pc_out !== 32'h8000_0104) begin n_fail++; $display("FAIL bp_pc: got %h expected %h", pc_out, 32'h8000_0104); end
  endtask

  task automatic test_spurious_held();
    imem_req_ready = 1'b1;
    tick();                         // -> WAIT
    imem_req_ready = 1'b0;
    pc_in   = 32'h0000_1234;
    pc_w_en = 1'b1;
    tick();                         // ignored in WAIT
    pc_w_en = 1'b0;
    n_checks++; if (pc_out !== 32'h8000_0104) begin n_fail++; $display("FAIL spur_pc: got %h expected %h", pc_out, 32'h8000_0104); end
    n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL spur_cnt: got %0d expected 3", fetch_cnt); end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0030_0193;
    tick();                         // -> HOLD
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    tick();                         // -> EXEC
    inst_ready      = 1'b0;
    pc_in   = 32'h8000_0108;
    pc_w_en = 1'b1;
    tick();                         // commit -> REQ
    pc_in   = 32'h8000_0200;        // must not be taken while still held
    tick();
    tick();
    pc_w_en = 1'b0;
    n_checks++; if (fetch_cnt !== 32'd4) begin n_fail++; $display("FAIL held_cnt: got %0d expected 4", fetch_cnt); end
    n_checks++; if (pc_out !== 32'h8000_0108) begin n_fail++; $display("FAIL held_pc: got %h expected %h", pc_out, 32'h8000_0108); end
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL held_req: got %b expected 1", imem_req_valid); end
  endtask

  task automatic test_misaligned();
    go_exec(32'h0040_0213);
    pc_in   = 32'h8000_0002;
    pc_w_en = 1'b1;
    tick();
    pc_w_en = 1'b0;
    n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b expected 1", fetch_err); end
    n_checks++; if (pc_out !== 32'h8000_0002) begin n_fail++; $display("FAIL mis_pc: got %h expected %h", pc_out, 32'h8000_0002); end
    n_checks++; if (fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL mis_cnt: got %0d expected 5", fetch_cnt); end
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    inst_ready      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL err_req[%0d]: got %b expected 0", i, imem_req_valid); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL err_iv[%0d]: got %b expected 0", i, inst_valid); end
      n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky[%0d]: got %b expected 1", i, fetch_err); end
    end
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL mis_rst_err: got %b expected 0", fetch_err); end
    n_checks++; if (pc_out !== 32'h8000_0000) begin n_fail++; $display("FAIL mis_rst_pc: got %h expected %h", pc_out, 32'h8000_0000); end
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL mis_rst_req: got %b expected 1", imem_req_valid); end
  endtask

  task automatic test_reset_mid_fetch();
    pc_in   = 32'h8000_0004;
    pc_w_en = 1'b0;
    go_exec(32'h0050_0293);
    pc_w_en = 1'b1;
    tick();                         // cnt = 1, -> REQ
    pc_w_en = 1'b0;
    imem_req_ready = 1'b1;
    tick();                         // -> WAIT
    imem_req_ready = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_wait: got %b expected 0", imem_req_valid); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    imem_resp_valid = 1'b1;         // stale response after release
    imem_resp_data  = 32'hBAD0_BAD0;
    tick();
    imem_resp_valid = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b expected 1", imem_req_valid); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_iv: got %b expected 0", inst_valid); end
    n_checks++; if (imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL mid_addr: got %h expected %h", imem_addr, 32'h8000_0000); end
    n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", fetch_cnt); end
    tick();
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL mid_inst: got %h expected 0", inst); end
    imem_req_ready  = 1'b1;
    tick();                         // -> WAIT
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0060_0313;
    tick();                         // -> HOLD
    imem_resp_valid = 1'b0;
    n_checks++; if (inst !== 32'h0060_0313) begin n_fail++; $display("FAIL mid_refetch: got %h expected %h", inst, 32'h0060_0313); end
    n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL mid_refetch_iv: got %b expected 1", inst_valid); end
  endtask

  initial begin
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    pc_in           = 32'h0;
    pc_w_en         = 1'b0;
    test_reset();
    test_free_run();
    test_seq_commit();
    test_backpressure();
    test_spurious_held();
    test_misaligned();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
